// File: rtl/sram_port_arbiter_if.sv
// Request, response and SRAM-macro signals of the two-port SRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [MASK_W-1:0] req0_wmask;
  logic              resp0_valid;
  logic [DATA_W-1:0] resp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [MASK_W-1:0] req1_wmask;
  logic              resp1_valid;
  logic [DATA_W-1:0] resp1_rdata;

  logic              init_done;

  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [MASK_W-1:0] sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
    output req0_ready, resp0_valid, resp0_rdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
    output req1_ready, resp1_valid, resp1_rdata,
    output init_done,
    output sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_wmask,
    input  req0_ready, resp0_valid, resp0_rdata,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_wmask,
    input  req1_ready, resp1_valid, resp1_rdata,
    input  init_done,
    input  sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Zero-fills a single-port SRAM after reset, then shares its RW port between
// two requesters round-robin, one access per cycle, read data one cycle later.
module sram_port_arbiter #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 32,
  parameter int MASK_W        = 4,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  sram_port_arbiter_if.slave  bus
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] scrub_cnt;
  logic              init_done_q;
  logic              last;
  logic              gnt0;
  logic              gnt1;
  logic              run;
  logic              rd_vld_p1;
  logic              rd_port_p1;

  // Scrub / run state machine
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= (INIT_ON_RESET != 0) ? S_INIT : S_RUN;
      scrub_cnt   <= '0;
      init_done_q <= (INIT_ON_RESET == 0);
    end else begin
      case (state)
        S_INIT: begin
          scrub_cnt <= scrub_cnt + ADDR_W'(1);
          if (scrub_cnt == LAST_ADDR) begin
            state       <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  assign bus.init_done = init_done_q;

  // reset_n gating keeps ready and sram_en low while reset is held
  assign run = (state == S_RUN) && reset_n;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt0 = last;
        gnt1 = !last;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wmode = 1'b0;
    bus.sram_addr  = bus.req0_addr;
    bus.sram_wmask = {MASK_W{1'b0}};
    bus.sram_wdata = bus.req0_wdata;
    if (state == S_INIT) begin
      bus.sram_en    = reset_n;
      bus.sram_wmode = 1'b1;
      bus.sram_addr  = scrub_cnt;
      bus.sram_wmask = {MASK_W{1'b1}};
      bus.sram_wdata = {DATA_W{1'b0}};
    end else if (gnt1) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = bus.req1_write;
      bus.sram_addr  = bus.req1_addr;
      bus.sram_wmask = bus.req1_write ? bus.req1_wmask : {MASK_W{1'b0}};
      bus.sram_wdata = bus.req1_wdata;
    end else if (gnt0) begin
      bus.sram_en    = 1'b1;
      bus.sram_wmode = bus.req0_write;
      bus.sram_wmask = bus.req0_write ? bus.req0_wmask : {MASK_W{1'b0}};
    end
  end

  // Grant pointer and read tag; the tag is the one-cycle read pipeline stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last       <= 1'b1;
      rd_vld_p1  <= 1'b0;
      rd_port_p1 <= 1'b0;
    end else begin
      if (gnt0) begin
        last <= 1'b0;
      end else if (gnt1) begin
        last <= 1'b1;
      end
      rd_vld_p1  <= (gnt0 && !bus.req0_write) || (gnt1 && !bus.req1_write);
      rd_port_p1 <= gnt1;
    end
  end

  // Response stage: the macro's rdata passes straight through
  assign bus.resp0_valid = rd_vld_p1 && !rd_port_p1;
  assign bus.resp1_valid = rd_vld_p1 && rd_port_p1;
  assign bus.resp0_rdata = bus.sram_rdata;
  assign bus.resp1_rdata = bus.sram_rdata;

endmodule
